stopwatch_ctrl: RTL and testbench

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_ctrl.sv | 168 ++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: debounced start/stop and lap/reset buttons, run/pause FSM,
// tick prescaler driving an external counter, and a 4-entry show-ahead lap FIFO.
module stopwatch_ctrl #(
  parameter int DEB_CYCLES = 4,
  parameter int TICK_DIV   = 10,
  parameter int LAP_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_ss,
  input  logic        btn_lr,
  input  logic [15:0] count_in,
  output logic        cnt_en,
  output logic        cnt_clr,
  output logic [1:0]  state,
  output logic        lap_valid,
  output logic [15:0] lap_data,
  input  logic        lap_ready,
  output logic [2:0]  lap_count,
  output logic        lap_ovf
);

  localparam int          PTR_W     = $clog2(LAP_DEPTH);
  localparam logic [7:0]  DEB_LAST  = 8'(DEB_CYCLES - 1);
  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
  localparam logic [2:0]  FULL_CNT  = 3'(LAP_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_t;

  logic [1:0] raw;
  logic [1:0] press;
  logic       ss_p;
  logic       lr_p;

  assign raw  = {btn_lr, btn_ss};
  assign ss_p = press[0];
  assign lr_p = press[1];

  // Per-button debouncer: level flips after DEB_CYCLES consecutive mismatching samples;
  // the press pulse is registered off the level's rising edge.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_deb
      logic       lvl_reg;
      logic       lvl_d_reg;
      logic       press_reg;
      logic [7:0] run_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          lvl_reg   <= 1'b0;
          lvl_d_reg <= 1'b0;
          press_reg <= 1'b0;
          run_reg   <= 8'd0;
        end else begin
          lvl_d_reg <= lvl_reg;
          press_reg <= lvl_reg & ~lvl_d_reg;
          if (raw[gi] == lvl_reg) begin
            run_reg <= 8'd0;
          end else if (run_reg == DEB_LAST) begin
            lvl_reg <= raw[gi];
            run_reg <= 8'd0;
          end else begin
            run_reg <= run_reg + 8'd1;
          end
        end
      end

      assign press[gi] = press_reg;
    end
  endgenerate

  state_t      state_reg, state_next;
  logic        clr_reg, clr_next;
  logic        push, flush;
  logic [15:0] presc_reg;

  // Start/stop has priority; a coincident lap/reset press is dropped.
  always_comb begin
    state_next = state_reg;
    clr_next   = 1'b0;
    push       = 1'b0;
    flush      = 1'b0;
    if (ss_p) begin
      case (state_reg)
        IDLE:    state_next = RUN;
        RUN:     state_next = PAUSE;
        PAUSE:   state_next = RUN;
        default: state_next = IDLE;
      endcase
    end else if (lr_p) begin
      case (state_reg)
        RUN:   push = 1'b1;
        PAUSE: begin
          clr_next   = 1'b1;
          flush      = 1'b1;
          state_next = IDLE;
        end
        default: clr_next = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      clr_reg   <= 1'b0;
      presc_reg <= 16'd0;
    end else begin
      state_reg <= state_next;
      clr_reg   <= clr_next;
      if (state_reg == RUN)
        presc_reg <= (presc_reg == TICK_LAST) ? 16'd0 : presc_reg + 16'd1;
      else if (state_reg == IDLE)
        presc_reg <= 16'd0;
    end
  end

  assign cnt_en  = (state_reg == RUN) && (presc_reg == TICK_LAST);
  assign cnt_clr = clr_reg;
  assign state   = state_reg;

  logic [15:0]      mem [LAP_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [2:0]       count_reg;
  logic             ovf_reg;
  logic             pop, full, push_ok;

  assign pop     = (count_reg != 3'd0) && lap_ready;
  assign full    = (count_reg == FULL_CNT);
  assign push_ok = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr_reg] <= count_in;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= 3'd0;
      ovf_reg    <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   count_reg <= count_reg + 3'd1;
        2'b01:   count_reg <= count_reg - 3'd1;
        default: count_reg <= count_reg;
      endcase
      if (push && full && !pop)
        ovf_reg <= 1'b1;
    end
  end

  assign lap_valid = (count_reg != 3'd0);
  assign lap_data  = mem[rd_ptr_reg];
  assign lap_count = count_reg;
  assign lap_ovf   = ovf_reg;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Randomized bench for stopwatch_ctrl: button/ready/count stimulus compared each cycle
// against a sample-history reference model with a queue-based lap FIFO.
module tb_stopwatch_ctrl;

  localparam int DEB  = 4;
  localparam int TD   = 10;
  localparam int NCYC = 4000;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_ss, btn_lr;
  logic [15:0] count_in;
  logic        cnt_en, cnt_clr;
  logic [1:0]  state;
  logic        lap_valid;
  logic [15:0] lap_data;
  logic        lap_ready;
  logic [2:0]  lap_count;
  logic        lap_ovf;

  stopwatch_ctrl #(.DEB_CYCLES(DEB), .TICK_DIV(TD), .LAP_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .btn_ss(btn_ss), .btn_lr(btn_lr), .count_in(count_in),
    .cnt_en(cnt_en), .cnt_clr(cnt_clr), .state(state), .lap_valid(lap_valid),
    .lap_data(lap_data), .lap_ready(lap_ready), .lap_count(lap_count), .lap_ovf(lap_ovf)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Reference model: 0 IDLE, 1 RUN, 2 PAUSE
  int          m_state;
  int          m_presc;
  bit          m_clr;
  bit          m_ovf;
  logic [15:0] m_q[$];
  bit          raw_ss[NCYC+2], raw_lr[NCYC+2];
  bit          deb_ss[NCYC+2], deb_lr[NCYC+2];
  int          floor_c;
  int          n_push, n_ovf, n_flush, n_tick;

  // New debounced level: flips only if the last DEB samples since reset all disagree.
  function automatic bit settle(input bit cur, input int c, input bit is_lr);
    for (int k = c - DEB + 1; k <= c; k++) begin
      if (k <= floor_c) return cur;
      if ((is_lr ? raw_lr[k] : raw_ss[k]) == cur) return cur;
    end
    return ~cur;
  endfunction

  task automatic model_step(input int c);
    bit ssp, lrp, pop, full, push, flush;
    int old;
    raw_ss[c] = btn_ss;
    raw_lr[c] = btn_lr;
    if (rst) begin
      m_state = 0; m_presc = 0; m_clr = 0; m_ovf = 0;
      m_q.delete();
      deb_ss[c-1] = 0; deb_ss[c] = 0; deb_ss[c+1] = 0;
      deb_lr[c-1] = 0; deb_lr[c] = 0; deb_lr[c+1] = 0;
      floor_c = c;
      return;
    end
    ssp   = deb_ss[c-1] && !deb_ss[c-2];
    lrp   = deb_lr[c-1] && !deb_lr[c-2];
    pop   = (m_q.size() > 0) && lap_ready;
    full  = (m_q.size() == 4);
    push  = 0;
    flush = 0;
    old   = m_state;
    m_clr = 0;
    if (ssp) m_state = (old == 1) ? 2 : 1;
    else if (lrp) begin
      if (old == 1) push = 1;
      else if (old == 2) begin flush = 1; m_clr = 1; m_state = 0; end
      else m_clr = 1;
    end
    if (old == 1) begin
      if (m_presc == TD - 1) n_tick++;
      m_presc = (m_presc == TD - 1) ? 0 : m_presc + 1;
    end else if (old == 0) m_presc = 0;
    if (flush) begin
      m_q.delete(); m_ovf = 0; n_flush++;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (push) begin
        if (!full || pop) begin m_q.push_back(count_in); n_push++; end
        else begin m_ovf = 1; n_ovf++; end
      end
    end
    deb_ss[c+1] = settle(deb_ss[c], c, 1'b0);
    deb_lr[c+1] = settle(deb_lr[c], c, 1'b1);
  endtask

  int hold_ss, hold_lr, rdy_mode;

  initial begin
    rst = 1'b1; btn_ss = 1'b0; btn_lr = 1'b0; count_in = 16'h0; lap_ready = 1'b0;
    hold_ss = 0; hold_lr = 0; rdy_mode = 0;
    n_push = 0; n_ovf = 0; n_flush = 0; n_tick = 0;
    m_state = 0; m_presc = 0; m_clr = 0; m_ovf = 0;
    for (int k = 0; k < 3; k++) begin deb_ss[k] = 0; deb_lr[k] = 0; end
    floor_c = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int c = 2; c < NCYC; c++) begin
      cyc = c;
      check("state", 32'(state), 32'(m_state));
      check("cnt_en", 32'(cnt_en), 32'((m_state == 1) && (m_presc == TD - 1)));
      check("cnt_clr", 32'(cnt_clr), 32'(m_clr));
      check("en_clr_excl", 32'(cnt_en & cnt_clr), 32'd0);
      check("lap_valid", 32'(lap_valid), 32'(m_q.size() > 0));
      check("lap_count", 32'(lap_count), 32'(m_q.size()));
      check("lap_ovf", 32'(lap_ovf), 32'(m_ovf));
      if (m_q.size() > 0) check("lap_data", 32'(lap_data), 32'(m_q[0]));

      rst = (c < 4) || ($urandom_range(0, 599) == 0);
      if (hold_ss == 0) begin
        btn_ss  = 1'($urandom_range(0, 1));
        hold_ss = $urandom_range(1, 14);
        if ($urandom_range(0, 5) == 0) begin btn_lr = btn_ss; hold_lr = hold_ss; end
      end
      if (hold_lr == 0) begin
        btn_lr  = 1'($urandom_range(0, 1));
        hold_lr = $urandom_range(1, 12);
      end
      hold_ss--;
      hold_lr--;
      if (c % 150 == 0) rdy_mode = $urandom_range(0, 2);
      lap_ready = (rdy_mode == 2) ? 1'b1 :
                  (rdy_mode == 1) ? 1'($urandom_range(0, 3) == 0) : 1'b0;
      count_in = 16'($urandom);

      @(posedge clk);
      model_step(c);
      @(negedge clk);
    end
    $display("coverage: pushes=%0d overflows=%0d flushes=%0d ticks=%0d", n_push, n_ovf, n_flush, n_tick);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
